// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain
// Description : Parametrised multi-stage pipeline register with per-stage
//               valid bits and valid/ready handshakes on both ends. Empty
//               stages accept from upstream even when downstream is stalled
//               (bubble collapsing), so the chain absorbs up to STAGES beats.
//               A synchronous flush drops every beat without touching data.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-low reset
//               flush      - synchronous clear of all valid bits
//               in_valid   - producer presents a beat
//               in_ready   - chain can accept a beat this cycle
//               in_data    - producer data (WIDTH bits)
//               out_valid  - last stage holds a beat
//               out_ready  - consumer accepts a beat this cycle
//               out_data   - last-stage data (WIDTH bits)
//               count      - number of valid stages, 0..STAGES
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STAGES    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(STAGES+1)-1:0]  count
);

  localparam int unsigned CW = $clog2(STAGES + 1);

  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            v_d;
  logic [STAGES-1:0][WIDTH-1:0] d_q;
  logic [STAGES-1:0][WIDTH-1:0] d_in;
  logic [STAGES-1:0]            adv;
  logic [STAGES-1:0]            can_acc;
  logic [STAGES-1:0]            load;
  logic [CW-1:0]                count_q;
  logic [CW-1:0]                count_d;
  logic                         in_fire;
  logic                         out_fire;

  // Advance ripples from the output side toward the input side: a stage may
  // accept when it is empty or its own beat is leaving this edge.
  always_comb begin
    logic down_acc;
    adv      = '0;
    can_acc  = '0;
    down_acc = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i]     = v_q[i] & down_acc;
      can_acc[i] = ~v_q[i] | adv[i];
      down_acc   = can_acc[i];
    end
  end

  assign in_ready = can_acc[0] & ~flush & reset;
  assign in_fire  = in_valid & in_ready;
  // A flush voids the output handshake on the same edge.
  assign out_fire = adv[STAGES-1] & ~flush;

  // Per-stage load enable and data source.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign load[gi] = in_fire;
      assign d_in[gi] = in_data;
    end else begin : g_body
      assign load[gi] = adv[gi-1] & ~flush;
      assign d_in[gi] = d_q[gi-1];
    end
  end

  // Next valid state: a new beat arriving wins over the current beat leaving.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush) begin
        v_d[i] = 1'b0;
      end else if (load[i]) begin
        v_d[i] = 1'b1;
      end else if (adv[i]) begin
        v_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_fire) - CW'(out_fire);
    end
  end

  // Data registers only load on an accepted beat; draining leaves them intact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      d_q     <= {STAGES{RESET_VAL}};
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          d_q[i] <= d_in[i];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign count     = count_q;

endmodule
`default_nettype wire
